// File: rtl/layer_sequencer.sv
// Multi-layer sequencer: runs an input vector through N passes of the shared
// neuron layer, collecting out-of-order per-neuron outputs and feeding them back.

module layer_sequencer_lane #(
  parameter int INPUT_SIZE = 9,
  parameter int ADDR_SIZE  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  cap,
  input  logic                  act,
  input  logic [ADDR_SIZE-1:0]  raw,
  output logic                  coll,
  output logic [INPUT_SIZE-1:0] nxt
);
  localparam int unsigned MAXV = (1 << INPUT_SIZE) - 1;

  logic [INPUT_SIZE-1:0] val, sat;

  assign sat = (32'(raw) > MAXV) ? '1 : raw[INPUT_SIZE-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val  <= '0;
      coll <= 1'b0;
    end else if (clr) begin
      coll <= 1'b0;
    end else if (cap) begin
      val  <= sat;
      coll <= 1'b1;
    end
  end

  // Forward this cycle's capture so completion can load results without a bubble
  assign nxt = !act ? '0 : (cap ? sat : val);
endmodule

module layer_sequencer #(
  parameter int NUM_NEURON = 6,
  parameter int INPUT_SIZE = 9,
  parameter int ADDR_SIZE  = 10,
  parameter int LAYER_MAX  = 4,
  parameter int LAYER_BITS = 3,
  parameter logic [NUM_NEURON*LAYER_MAX-1:0] LAYER_MASK = {(NUM_NEURON*LAYER_MAX){1'b1}}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_valid,
  output logic                             start_ready,
  input  logic [NUM_NEURON*INPUT_SIZE-1:0] start_input,
  input  logic [LAYER_BITS-1:0]            num_layers,
  input  logic                             abort,
  input  logic [NUM_NEURON*ADDR_SIZE-1:0]  layer_output,
  input  logic [NUM_NEURON-1:0]            layer_output_valid,
  output logic                             layer_start,
  output logic [NUM_NEURON-1:0]            active,
  output logic [NUM_NEURON*INPUT_SIZE-1:0] layer_input,
  output logic [LAYER_BITS-1:0]            layer_num,
  output logic [NUM_NEURON*INPUT_SIZE-1:0] final_output,
  output logic                             final_valid,
  input  logic                             final_ready,
  output logic                             busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, nxt_state;
  logic [LAYER_BITS-1:0]            last_idx, clamp;
  logic [NUM_NEURON-1:0]            cap, coll;
  logic [NUM_NEURON*INPUT_SIZE-1:0] outv;
  logic                             done, last, kill;

  function automatic logic [NUM_NEURON-1:0] mask_of(input logic [LAYER_BITS-1:0] k);
    mask_of = '0;
    for (int j = 0; j < LAYER_MAX; j++)
      if (k == LAYER_BITS'(j)) mask_of = LAYER_MASK[j*NUM_NEURON +: NUM_NEURON];
  endfunction

  for (genvar i = 0; i < NUM_NEURON; i++) begin : g_lane
    assign cap[i] = (state == WAIT) & active[i] & layer_output_valid[i];
    layer_sequencer_lane #(.INPUT_SIZE(INPUT_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (state == ISSUE),
      .cap  (cap[i]),
      .act  (active[i]),
      .raw  (layer_output[i*ADDR_SIZE +: ADDR_SIZE]),
      .coll (coll[i]),
      .nxt  (outv[i*INPUT_SIZE +: INPUT_SIZE])
    );
  end

  assign done        = (state == WAIT) && ((coll | cap) == active);
  assign last        = (layer_num == last_idx);
  assign kill        = abort && (state != IDLE);
  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign layer_start = (state == ISSUE);

  always_comb begin
    clamp = num_layers;
    if (num_layers == '0)                           clamp = LAYER_BITS'(1);
    else if (num_layers > LAYER_BITS'(LAYER_MAX))   clamp = LAYER_BITS'(LAYER_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (start_valid) nxt_state = ISSUE;
      ISSUE:   nxt_state = WAIT;
      WAIT:    if (done) nxt_state = last ? DONE : ISSUE;
      DONE:    if (final_ready) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
    if (kill) nxt_state = IDLE;
  end

  // active is loaded on entry to ISSUE so it already holds the layer mask there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active       <= '0;
      layer_input  <= '0;
      layer_num    <= '0;
      last_idx     <= '0;
      final_output <= '0;
      final_valid  <= 1'b0;
    end else if (kill) begin
      active      <= '0;
      layer_num   <= '0;
      final_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          layer_input <= start_input;
          layer_num   <= '0;
          last_idx    <= clamp - LAYER_BITS'(1);
          active      <= mask_of('0);
        end
        WAIT: if (done) begin
          if (last) begin
            final_output <= outv;
            final_valid  <= 1'b1;
          end else begin
            layer_input <= outv;
            layer_num   <= layer_num + LAYER_BITS'(1);
            active      <= mask_of(layer_num + LAYER_BITS'(1));
          end
        end
        DONE: if (final_ready) begin
          final_valid <= 1'b0;
          layer_num   <= '0;
          active      <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: stimulus pushes expected final vectors,
// a negedge monitor pops them on each final handshake.

module tb_layer_sequencer;
  localparam int N  = 6;
  localparam int IS = 9;
  localparam int AS = 10;
  localparam int LM = 4;
  localparam int LB = 3;
  localparam logic [N*LM-1:0] MASK = {6'h3F, 6'h3F, 6'h07, 6'h3F};

  logic            clk = 0, rst = 1;
  logic            start_valid = 0, start_ready, abort = 0;
  logic [N*IS-1:0] start_input = '0;
  logic [LB-1:0]   num_layers = '0;
  logic [N*AS-1:0] layer_output = '0;
  logic [N-1:0]    layer_output_valid = '0;
  logic            layer_start, final_valid, final_ready = 0, busy;
  logic [N-1:0]    active;
  logic [N*IS-1:0] layer_input, final_output;
  logic [LB-1:0]   layer_num;

  layer_sequencer #(.NUM_NEURON(N), .INPUT_SIZE(IS), .ADDR_SIZE(AS), .LAYER_MAX(LM),
                    .LAYER_BITS(LB), .LAYER_MASK(MASK)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .start_input(start_input), .num_layers(num_layers), .abort(abort),
    .layer_output(layer_output), .layer_output_valid(layer_output_valid),
    .layer_start(layer_start), .active(active), .layer_input(layer_input),
    .layer_num(layer_num), .final_output(final_output), .final_valid(final_valid),
    .final_ready(final_ready), .busy(busy));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, pulses = 0;
  logic [N*IS-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst && layer_start) pulses++;

  always @(negedge clk) begin
    if (!rst && final_valid && final_ready) begin
      if (exp_q.size() == 0) chk("final_unexpected", 64'(final_output), 64'hDEAD);
      else chk("final_output", 64'(final_output), 64'(exp_q.pop_front()));
    end
  end

  function automatic logic [N*IS-1:0] v9(input int a0, a1, a2, a3, a4, a5);
    int a[6] = '{a0, a1, a2, a3, a4, a5};
    v9 = '0;
    for (int i = 0; i < N; i++) v9[i*IS +: IS] = IS'(a[i]);
  endfunction

  function automatic logic [N*AS-1:0] v10(input int a0, a1, a2, a3, a4, a5);
    int a[6] = '{a0, a1, a2, a3, a4, a5};
    v10 = '0;
    for (int i = 0; i < N; i++) v10[i*AS +: AS] = AS'(a[i]);
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [N*IS-1:0] vec, input int n);
    int k = 0;
    while (!start_ready && k < 50) begin cyc(); k++; end
    if (!start_ready) chk("start_ready_timeout", 0, 1);
    start_valid = 1; start_input = vec; num_layers = LB'(n);
    cyc();
    start_valid = 0;
  endtask

  // Wait for the ISSUE cycle of layer ln, check it, then step into WAIT
  task automatic wait_issue(input int ln, input logic [N-1:0] m);
    int k = 0;
    while (!layer_start && k < 50) begin cyc(); k++; end
    if (!layer_start) chk("issue_timeout", 0, 1);
    chk("layer_num", 64'(layer_num), 64'(ln));
    chk("active", 64'(active), 64'(m));
    cyc();
  endtask

  task automatic emit(input logic [N-1:0] v, input logic [N*AS-1:0] raw);
    layer_output_valid = v; layer_output = raw;
    cyc();
    layer_output_valid = '0;
  endtask

  task automatic drain();
    final_ready = 1; cyc(); final_ready = 0;
  endtask

  initial begin
    int p0;
    cyc(); cyc();
    chk("rst_start_ready", 64'(start_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_layer_start", 64'(layer_start), 0);
    chk("rst_active", 64'(active), 0);
    chk("rst_layer_input", 64'(layer_input), 0);
    chk("rst_layer_num", 64'(layer_num), 0);
    chk("rst_final", 64'({final_valid, final_output}), 0);
    rst = 0; cyc();

    // single layer, all valids in second WAIT cycle
    p0 = pulses;
    start(v9(1, 2, 3, 4, 5, 6), 1);
    chk("t1_layer_input", 64'(layer_input), 64'(v9(1, 2, 3, 4, 5, 6)));
    wait_issue(0, 6'h3F);
    cyc();
    exp_q.push_back(v9(5, 6, 7, 8, 9, 10));
    emit(6'h3F, v10(5, 6, 7, 8, 9, 10));
    chk("t1_final_valid", 64'(final_valid), 1);
    chk("t1_busy_done", 64'(busy), 1);
    drain();
    chk("t1_busy_after", 64'(busy), 0);
    chk("t1_hold_output", 64'(final_output), 64'(v9(5, 6, 7, 8, 9, 10)));
    chk("t1_pulses", 64'(pulses - p0), 1);

    // three layers, out-of-order valids, layer 1 masked to neurons 0..2
    p0 = pulses;
    start(v9(9, 9, 9, 9, 9, 9), 3);
    wait_issue(0, 6'h3F);
    emit(6'h08, v10(0, 0, 0, 30, 0, 0));
    emit(6'h01, v10(10, 0, 0, 0, 0, 0));
    emit(6'h36, v10(0, 11, 12, 0, 14, 15));
    chk("t2_l1_input", 64'(layer_input), 64'(v9(10, 11, 12, 30, 14, 15)));
    wait_issue(1, 6'h07);
    emit(6'h20, v10(0, 0, 0, 0, 0, 99));
    emit(6'h01, v10(20, 0, 0, 0, 0, 0));
    chk("t2_not_done", 64'(layer_start), 0);
    emit(6'h1E, v10(0, 21, 22, 33, 34, 0));
    chk("t2_l2_input", 64'(layer_input), 64'(v9(20, 21, 22, 0, 0, 0)));
    wait_issue(2, 6'h3F);
    emit(6'h08, v10(0, 0, 0, 43, 0, 0));
    emit(6'h01, v10(40, 0, 0, 0, 0, 0));
    exp_q.push_back(v9(40, 41, 42, 43, 44, 45));
    emit(6'h36, v10(0, 41, 42, 0, 44, 45));
    drain();
    chk("t2_pulses", 64'(pulses - p0), 3);

    // saturation and overwrite
    start(v9(0, 0, 0, 0, 0, 0), 1);
    wait_issue(0, 6'h3F);
    emit(6'h01, v10(700, 0, 0, 0, 0, 0));
    emit(6'h01, v10(12, 0, 0, 0, 0, 0));
    exp_q.push_back(v9(12, 511, 511, 511, 0, 300));
    emit(6'h3E, v10(0, 700, 512, 1023, 0, 300));
    drain();

    // num_layers=0 clamps to one layer
    p0 = pulses;
    start(v9(1, 1, 1, 1, 1, 1), 0);
    wait_issue(0, 6'h3F);
    exp_q.push_back(v9(7, 8, 9, 10, 11, 12));
    emit(6'h3F, v10(7, 8, 9, 10, 11, 12));
    chk("t4_clamp0_done", 64'(final_valid), 1);
    drain();
    chk("t4_clamp0_pulses", 64'(pulses - p0), 1);

    // num_layers=7 clamps to four layers, then backpressure
    p0 = pulses;
    start(v9(2, 2, 2, 2, 2, 2), 7);
    for (int l = 0; l < 4; l++) begin
      wait_issue(l, (l == 1) ? 6'h07 : 6'h3F);
      emit(6'h3F, v10(l*10, l*10+1, l*10+2, l*10+3, l*10+4, l*10+5));
    end
    exp_q.push_back(v9(30, 31, 32, 33, 34, 35));
    for (int c = 0; c < 5; c++) begin
      chk("t4_bp_valid", 64'(final_valid), 1);
      chk("t4_bp_output", 64'(final_output), 64'(v9(30, 31, 32, 33, 34, 35)));
      chk("t4_bp_start_ready", 64'(start_ready), 0);
      cyc();
    end
    chk("t4_layer_num_max", 64'(layer_num), 3);
    drain();
    chk("t4_pulses", 64'(pulses - p0), 4);

    // abort in the same cycle as layer-1 completion
    start(v9(3, 3, 3, 3, 3, 3), 3);
    wait_issue(0, 6'h3F);
    emit(6'h3F, v10(1, 2, 3, 4, 5, 6));
    wait_issue(1, 6'h07);
    abort = 1;
    emit(6'h07, v10(1, 2, 3, 0, 0, 0));
    abort = 0;
    chk("t5_idle", 64'({start_ready, busy}), 64'(2'b10));
    chk("t5_no_final", 64'(final_valid), 0);
    chk("t5_layer_num", 64'(layer_num), 0);
    chk("t5_active", 64'(active), 0);
    p0 = pulses;
    cyc(); cyc();
    chk("t5_no_issue", 64'(pulses - p0), 0);

    // asynchronous reset in ISSUE
    start(v9(4, 4, 4, 4, 4, 4), 2);
    chk("t6_in_issue", 64'(layer_start), 1);
    rst = 1; #1;
    chk("t6_layer_start", 64'(layer_start), 0);
    chk("t6_start_ready", 64'(start_ready), 1);
    chk("t6_layer_input", 64'(layer_input), 0);
    cyc(); rst = 0; cyc();

    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Multi-layer sequencer for the layer-multiplexed network. It accepts an external input vector through a valid/ready handshake and runs it through a runtime-selectable number of passes over the shared neuron layer. Each pass enables a per-layer subset of neurons and collects their out-of-order outputs. Each layer's outputs are fed back as the next layer's inputs, and the final vector is presented through an output valid/ready handshake.

Parameters:
- NUM_NEURON, 6: physical neurons in the shared layer.
- INPUT_SIZE, 9: width of one neuron input/output value.
- ADDR_SIZE, 10: width of one raw neuron output.
- LAYER_MAX, 4: maximum number of layers; must be at least 1.
- LAYER_BITS, 3: width of layer index and count ports; must be at least log2(LAYER_MAX)+1.
- LAYER_MASK, {LAYER_MAX{NUM_NEURON{1'b1}}}: packed NUM_NEURON*LAYER_MAX bits; slice k is the active-neuron mask for layer k. Every slice must be nonzero.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start_valid  in  1  input vector offered.
- start_ready  out  1  sequencer can accept; high only in IDLE.
- start_input  in  NUM_NEURON*INPUT_SIZE  first-layer input vector.
- num_layers  in  LAYER_BITS  number of layers for this run; sampled on accept.
- abort  in  1  synchronous cancel of the run in progress.
- layer_output  in  NUM_NEURON*ADDR_SIZE  raw neuron outputs.
- layer_output_valid  in  NUM_NEURON  per-neuron output strobe.
- layer_start  out  1  one-cycle pulse that starts the neurons.
- active  out  NUM_NEURON  active mask for the current layer.
- layer_input  out  NUM_NEURON*INPUT_SIZE  current layer input vector; registered.
- layer_num  out  LAYER_BITS  current layer index; doubles as the weight BRAM address.
- final_output  out  NUM_NEURON*INPUT_SIZE  result vector.
- final_valid  out  1  result offered.
- final_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE; start_ready=1; layer_start=0; active=0; layer_input=0; layer_num=0; final_output=0; final_valid=0; busy=0; collect register=0.
- States are IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - On start_valid & start_ready, latch start_input into layer_input and set layer_num=0.
  - Latch the clamped layer count: num_layers 0 is treated as 1; values above LAYER_MAX are treated as LAYER_MAX.
  - Go to ISSUE.
- ISSUE (exactly one cycle):
  - layer_start=1 and active=LAYER_MASK slice[layer_num].
  - Clear the collect register; go to WAIT.
  - layer_start rises one cycle after the start accept.
- WAIT:
  - Each cycle, for each neuron i with active[i] & layer_output_valid[i], capture value i and set collected[i].
  - Value capture saturates: if the ADDR_SIZE value is at least 2^INPUT_SIZE, store 2^INPUT_SIZE-1; otherwise store the low INPUT_SIZE bits.
  - A repeated valid for an already-collected neuron overwrites its value.
  - Valids for inactive neurons are ignored.
  - Completion is (collected | this cycle's captures) == active. It may occur in the same cycle as the last valids.
  - On completion, if layer_num == count-1: load final_output from the captured values with inactive lanes zeroed, set final_valid=1, go to DONE.
  - Otherwise: load layer_input from the captured values with inactive lanes zeroed, increment layer_num, go to ISSUE.
- Valids arriving in IDLE, ISSUE or DONE are ignored.
- DONE:
  - Hold final_valid and final_output stable until final_ready.
  - On final_valid & final_ready: clear final_valid, set layer_num=0 and active=0, go to IDLE.
  - final_output keeps its last value after the handshake.
- Abort: in ISSUE, WAIT or DONE, return to IDLE next cycle with final_valid=0, active=0, layer_num=0 and layer_start=0. Abort outranks completion and the final handshake in the same cycle. Abort in IDLE has no effect.
- Reset mid-run: all outputs return to their reset values immediately (asynchronous).
- Latency per layer = 1 (ISSUE) + cycles until the last active valid + 0.
- layer_num never exceeds LAYER_MAX-1.

Test Plan:
- Single layer: num_layers=1, all neurons valid together in the second WAIT cycle, values 5..10 → final_valid after one layer_start pulse, final_output=inputs 5..10, busy drops the cycle after final_ready.
- Three layers, out-of-order valids: neuron 3 first, then 0, then the rest → exactly three layer_start pulses, layer_num 0→1→2, and each layer_input equals the previous layer's captures.
- Masking: LAYER_MASK slice1=6'b000111, a spurious valid on neuron 5 in layer 1 → ignored, lanes 3..5 of the next layer_input are 0, and the layer completes after neurons 0..2.
- Saturation and overwrite: neuron 0 output 700, then neuron 0 output 12 before completion → stored 12; a lone output of 700 stores 511.
- Clamping and backpressure: num_layers=0 runs 1 layer; num_layers=7 runs 4 layers; final_ready held low 5 cycles → final_valid and final_output stable throughout, start_ready=0.
- Abort and reset: abort asserted in WAIT of layer 1 in the same cycle as completion → IDLE next cycle with no final_valid; rst asserted mid-ISSUE → layer_start=0 immediately and start_ready=1.
